tomasulo_rs: RTL and testbench

TOMASULO_RS -- requirements
Module: tomasulo_rs

---
 rtl/tomasulo_rs.sv | 170 +++++++++++++++++
 tb/tb_tomasulo_rs.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_rs.sv
// Reservation station: holds renamed instructions until both operands arrive,
// snoops the CDB for results, and issues the oldest ready entry.
module tomasulo_rs #(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_W      = 32,
  parameter int INSN_W      = 32,
  parameter int TAG_W       = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               alloc_valid,
  output logic                               alloc_ready,
  input  logic [INSN_W-1:0]                  alloc_insn,
  input  logic [TAG_W-1:0]                   alloc_dst_tag,
  input  logic [DATA_W-1:0]                  alloc_src1_val,
  input  logic [TAG_W-1:0]                   alloc_src1_tag,
  input  logic                               alloc_src1_rdy,
  input  logic [DATA_W-1:0]                  alloc_src2_val,
  input  logic [TAG_W-1:0]                   alloc_src2_tag,
  input  logic                               alloc_src2_rdy,
  input  logic                               cdb_valid,
  input  logic [TAG_W-1:0]                   cdb_tag,
  input  logic [DATA_W-1:0]                  cdb_data,
  output logic                               issue_valid,
  input  logic                               issue_ready,
  output logic [INSN_W-1:0]                  issue_insn,
  output logic [TAG_W-1:0]                   issue_dst_tag,
  output logic [DATA_W-1:0]                  issue_src1,
  output logic [DATA_W-1:0]                  issue_src2,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   free_count
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  typedef struct packed {
    logic              valid;
    logic [INSN_W-1:0] insn;
    logic [TAG_W-1:0]  dst_tag;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_val;
    logic              s2_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_val;
    logic [IDX_W-1:0]  age;
  } entry_t;

  entry_t             entry_q [NUM_ENTRIES];
  entry_t             entry_d [NUM_ENTRIES];
  logic               lock_q, lock_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

  logic [CNT_W-1:0]   free_cnt;
  logic [IDX_W-1:0]   alloc_idx;
  logic               alloc_found;
  logic               any_elig;
  logic [IDX_W-1:0]   oldest_idx;
  logic [IDX_W-1:0]   oldest_age;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   issued_age;
  logic               do_alloc;
  logic               do_issue;

  // Free-slot count, lowest free index, and oldest eligible entry.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    free_cnt    = '0;
    alloc_idx   = '0;
    alloc_found = 1'b0;
    any_elig    = 1'b0;
    oldest_idx  = '0;
    oldest_age  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!entry_q[i].valid) begin
        free_cnt = free_cnt + CNT_W'(1);
        if (!alloc_found) begin
          alloc_idx   = IDX_W'(i);
          alloc_found = 1'b1;
        end
      end else if (entry_q[i].s1_rdy && entry_q[i].s2_rdy &&
                   (!any_elig || entry_q[i].age > oldest_age)) begin
        any_elig   = 1'b1;
        oldest_idx = IDX_W'(i);
        oldest_age = entry_q[i].age;
      end
    end
  end

  assign free_count  = free_cnt;
  assign alloc_ready = (free_cnt != '0) && !flush;
  // A stalled presentation stays on its entry; the lock guarantees it is still eligible.
  assign sel_idx     = lock_q ? lock_idx_q : oldest_idx;
  assign issue_valid = !flush && (lock_q || any_elig);
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_issue    = issue_valid && issue_ready;
  assign issued_age  = entry_q[sel_idx].age;

  assign issue_insn    = issue_valid ? entry_q[sel_idx].insn    : '0;
  assign issue_dst_tag = issue_valid ? entry_q[sel_idx].dst_tag : '0;
  assign issue_src1    = issue_valid ? entry_q[sel_idx].s1_val  : '0;
  assign issue_src2    = issue_valid ? entry_q[sel_idx].s2_val  : '0;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid) begin
        if (cdb_valid && !entry_q[i].s1_rdy && entry_q[i].s1_tag == cdb_tag) begin
          entry_d[i].s1_rdy = 1'b1;
          entry_d[i].s1_val = cdb_data;
        end
        if (cdb_valid && !entry_q[i].s2_rdy && entry_q[i].s2_tag == cdb_tag) begin
          entry_d[i].s2_rdy = 1'b1;
          entry_d[i].s2_val = cdb_data;
        end
        // Ages stay a dense 0..count-1 range: entries older than the issued one
        // close the gap, so the oldest age never exceeds NUM_ENTRIES-1.
        entry_d[i].age = entry_q[i].age + IDX_W'(do_alloc)
                       - IDX_W'(do_issue && entry_q[i].age > issued_age);
      end
      if (do_issue && sel_idx == IDX_W'(i)) entry_d[i].valid = 1'b0;
    end

    if (do_alloc) begin
      entry_d[alloc_idx].valid   = 1'b1;
      entry_d[alloc_idx].insn    = alloc_insn;
      entry_d[alloc_idx].dst_tag = alloc_dst_tag;
      entry_d[alloc_idx].s1_tag  = alloc_src1_tag;
      entry_d[alloc_idx].s2_tag  = alloc_src2_tag;
      entry_d[alloc_idx].age     = '0;
      if (!alloc_src1_rdy && cdb_valid && alloc_src1_tag == cdb_tag) begin
        entry_d[alloc_idx].s1_rdy = 1'b1;
        entry_d[alloc_idx].s1_val = cdb_data;
      end else begin
        entry_d[alloc_idx].s1_rdy = alloc_src1_rdy;
        entry_d[alloc_idx].s1_val = alloc_src1_val;
      end
      if (!alloc_src2_rdy && cdb_valid && alloc_src2_tag == cdb_tag) begin
        entry_d[alloc_idx].s2_rdy = 1'b1;
        entry_d[alloc_idx].s2_val = cdb_data;
      end else begin
        entry_d[alloc_idx].s2_rdy = alloc_src2_rdy;
        entry_d[alloc_idx].s2_val = alloc_src2_val;
      end
    end

    lock_d     = issue_valid && !issue_ready;
    lock_idx_d = sel_idx;

    if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_d[i].valid = 1'b0;
      lock_d = 1'b0;
    end
  end

  // NOTE: the whole entry array is reset, not just the valid bits; it is small,
  // and it keeps every stored field at a known value after reset.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q    <= '{default: '0};
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      entry_q    <= entry_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
endmodule

// File: tb/tb_tomasulo_rs.sv
// Self-checking bench for tomasulo_rs: directed vector table, hand-written
// corner sequences, and randomized traffic against an in-order queue model.
module tb_tomasulo_rs;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int IW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          alloc_valid, alloc_ready;
  logic [IW-1:0] alloc_insn;
  logic [TW-1:0] alloc_dst_tag;
  logic [DW-1:0] alloc_src1_val, alloc_src2_val;
  logic [TW-1:0] alloc_src1_tag, alloc_src2_tag;
  logic          alloc_src1_rdy, alloc_src2_rdy;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          issue_valid, issue_ready;
  logic [IW-1:0] issue_insn;
  logic [TW-1:0] issue_dst_tag;
  logic [DW-1:0] issue_src1, issue_src2;
  logic [3:0]    free_count;

  always #5 clk = ~clk;

  tomasulo_rs #(.NUM_ENTRIES(N), .DATA_W(DW), .INSN_W(IW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_insn(alloc_insn), .alloc_dst_tag(alloc_dst_tag),
    .alloc_src1_val(alloc_src1_val), .alloc_src1_tag(alloc_src1_tag), .alloc_src1_rdy(alloc_src1_rdy),
    .alloc_src2_val(alloc_src2_val), .alloc_src2_tag(alloc_src2_tag), .alloc_src2_rdy(alloc_src2_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_insn(issue_insn), .issue_dst_tag(issue_dst_tag),
    .issue_src1(issue_src1), .issue_src2(issue_src2),
    .free_count(free_count)
  );

  // Reference model: entries kept in allocation order, index 0 is the oldest.
  typedef struct {
    logic [IW-1:0] insn;
    logic [TW-1:0] dst;
    logic          r1, r2;
    logic [TW-1:0] t1, t2;
    logic [DW-1:0] v1, v2;
  } ment_t;

  ment_t         mq[$];
  logic          m_locked = 1'b0;
  logic [IW-1:0] m_lock_insn = '0;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_sel();
    if (m_locked)
      foreach (mq[i]) if (mq[i].insn == m_lock_insn) return i;
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  task automatic idle_inputs();
    alloc_valid = 0; alloc_insn = '0; alloc_dst_tag = '0;
    alloc_src1_val = '0; alloc_src1_tag = '0; alloc_src1_rdy = 0;
    alloc_src2_val = '0; alloc_src2_tag = '0; alloc_src2_rdy = 0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; issue_ready = 0; flush = 0;
  endtask

  task automatic set_alloc(input logic [IW-1:0] insn, input logic [DW-1:0] v1, input logic [TW-1:0] t1,
                           input logic r1, input logic [DW-1:0] v2, input logic [TW-1:0] t2, input logic r2);
    alloc_valid = 1; alloc_insn = insn; alloc_dst_tag = insn[TW-1:0];
    alloc_src1_val = v1; alloc_src1_tag = t1; alloc_src1_rdy = r1;
    alloc_src2_val = v2; alloc_src2_tag = t2; alloc_src2_rdy = r2;
  endtask

  // Compare outputs with the model, cross the clock edge, then advance the model.
  task automatic tick();
    int   s;
    logic eiv;
    logic can_alloc;
    #1;
    s         = model_sel();
    eiv       = !flush && (s >= 0);
    can_alloc = (mq.size() < N);
    check("issue_valid", issue_valid, eiv);
    check("free_count", free_count, 64'(N - mq.size()));
    check("alloc_ready", alloc_ready, can_alloc && !flush);
    if (eiv) begin
      check("issue_insn", issue_insn, mq[s].insn);
      check("issue_dst_tag", issue_dst_tag, mq[s].dst);
      check("issue_src1", issue_src1, mq[s].v1);
      check("issue_src2", issue_src2, mq[s].v2);
    end else begin
      check("issue_zero", |{issue_insn, issue_dst_tag, issue_src1, issue_src2}, 1'b0);
    end
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_locked = 1'b0;
    end else begin
      m_locked = eiv && !issue_ready;
      if (eiv) m_lock_insn = mq[s].insn;
      if (eiv && issue_ready) mq.delete(s);
      foreach (mq[i]) begin
        if (cdb_valid && !mq[i].r1 && mq[i].t1 == cdb_tag) begin mq[i].r1 = 1; mq[i].v1 = cdb_data; end
        if (cdb_valid && !mq[i].r2 && mq[i].t2 == cdb_tag) begin mq[i].r2 = 1; mq[i].v2 = cdb_data; end
      end
      if (alloc_valid && can_alloc) begin
        ment_t e;
        e.insn = alloc_insn; e.dst = alloc_dst_tag;
        e.t1 = alloc_src1_tag; e.t2 = alloc_src2_tag;
        e.r1 = alloc_src1_rdy || (cdb_valid && alloc_src1_tag == cdb_tag);
        e.v1 = (!alloc_src1_rdy && cdb_valid && alloc_src1_tag == cdb_tag) ? cdb_data : alloc_src1_val;
        e.r2 = alloc_src2_rdy || (cdb_valid && alloc_src2_tag == cdb_tag);
        e.v2 = (!alloc_src2_rdy && cdb_valid && alloc_src2_tag == cdb_tag) ? cdb_data : alloc_src2_val;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  typedef struct {
    logic          av;
    logic [IW-1:0] insn;
    logic [DW-1:0] v1, v2;
    logic [TW-1:0] t1, t2;
    logic          r1, r2;
    logic          cv;
    logic [TW-1:0] ct;
    logic [DW-1:0] cd;
    logic          ir, fl;
    logic          e_iv;
    logic [DW-1:0] e_s1, e_s2;
    logic [3:0]    e_fc;
    logic          e_ar;
  } vec_t;

  function automatic vec_t mk(logic av, logic [IW-1:0] insn, logic [DW-1:0] v1, logic [TW-1:0] t1, logic r1,
                              logic [DW-1:0] v2, logic [TW-1:0] t2, logic r2, logic cv, logic [TW-1:0] ct,
                              logic [DW-1:0] cd, logic ir, logic fl, logic e_iv, logic [DW-1:0] e_s1,
                              logic [DW-1:0] e_s2, logic [3:0] e_fc, logic e_ar);
    vec_t v;
    v.av = av; v.insn = insn; v.v1 = v1; v.t1 = t1; v.r1 = r1; v.v2 = v2; v.t2 = t2; v.r2 = r2;
    v.cv = cv; v.ct = ct; v.cd = cd; v.ir = ir; v.fl = fl;
    v.e_iv = e_iv; v.e_s1 = e_s1; v.e_s2 = e_s2; v.e_fc = e_fc; v.e_ar = e_ar;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    //            av insn  v1   t1 r1 v2    t2 r2 cv ct cd    ir fl | iv s1    s2    fc ar
    vecs[0] = mk(1, 1,    5,   0, 1, 7,    0, 1, 0, 0, 0,    1, 0,   0, 0,    0,    8, 1);
    vecs[1] = mk(0, 0,    0,   0, 0, 0,    0, 0, 0, 0, 0,    1, 0,   1, 5,    7,    7, 1);
    vecs[2] = mk(1, 2,    0,   3, 0, 1,    0, 1, 0, 0, 0,    1, 0,   0, 0,    0,    8, 1);
    vecs[3] = mk(0, 0,    0,   0, 0, 0,    0, 0, 0, 0, 0,    1, 0,   0, 0,    0,    7, 1);
    vecs[4] = mk(0, 0,    0,   0, 0, 0,    0, 0, 1, 3, 'hAA, 1, 0,   0, 0,    0,    7, 1);
    vecs[5] = mk(0, 0,    0,   0, 0, 0,    0, 0, 0, 0, 0,    1, 0,   1, 'hAA, 1,    7, 1);
    vecs[6] = mk(1, 3,    'h11, 9, 1, 0,   9, 0, 1, 9, 'h55, 1, 0,   0, 0,    0,    8, 1);
    vecs[7] = mk(0, 0,    0,   0, 0, 0,    0, 0, 0, 0, 0,    1, 0,   1, 'h11, 'h55, 7, 1);
    vecs[8] = mk(1, 4,    1,   0, 1, 2,    0, 1, 0, 0, 0,    1, 1,   0, 0,    0,    8, 0);
    vecs[9] = mk(0, 0,    0,   0, 0, 0,    0, 0, 0, 0, 0,    1, 0,   0, 0,    0,    8, 1);

    idle_inputs();
    reset = 1;
    #2;
    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_free_count", free_count, 4'd8);
    check("rst_alloc_ready", alloc_ready, 1'b1);
    check("rst_issue_zero", |{issue_insn, issue_dst_tag, issue_src1, issue_src2}, 1'b0);
    @(posedge clk); #3 reset = 0;
    @(posedge clk); #1;

    // Directed vector table: one row per cycle.
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      if (vecs[i].av) set_alloc(vecs[i].insn, vecs[i].v1, vecs[i].t1, vecs[i].r1, vecs[i].v2, vecs[i].t2, vecs[i].r2);
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_data = vecs[i].cd;
      issue_ready = vecs[i].ir; flush = vecs[i].fl;
      #1;
      check($sformatf("vec%0d_issue_valid", i), issue_valid, vecs[i].e_iv);
      check($sformatf("vec%0d_free_count", i), free_count, vecs[i].e_fc);
      check($sformatf("vec%0d_alloc_ready", i), alloc_ready, vecs[i].e_ar);
      if (vecs[i].e_iv) begin
        check($sformatf("vec%0d_src1", i), issue_src1, vecs[i].e_s1);
        check($sformatf("vec%0d_src2", i), issue_src2, vecs[i].e_s2);
      end
      tick();
    end

    // Selection lock: D presented and held while older C wakes up.
    idle_inputs(); set_alloc('h10, 0, 4, 0, 3, 0, 1); tick();
    idle_inputs(); set_alloc('h11, 8, 0, 1, 9, 0, 1); tick();
    idle_inputs(); cdb_valid = 1; cdb_tag = 4; cdb_data = 'h44; #1;
    check("lock_first_present", issue_insn, 'h11); tick();
    idle_inputs(); #1;
    check("lock_held_valid", issue_valid, 1'b1);
    check("lock_held_insn", issue_insn, 'h11); tick();
    idle_inputs(); issue_ready = 1; #1;
    check("lock_accept_insn", issue_insn, 'h11); tick();
    idle_inputs(); issue_ready = 1; #1;
    check("older_next_insn", issue_insn, 'h10);
    check("older_next_src1", issue_src1, 'h44); tick();

    // Fill all entries; only the first is ready.
    for (int i = 0; i < N; i++) begin
      idle_inputs(); set_alloc(IW'('h20 + i), i, 14, (i == 0), 1, 0, 1); tick();
    end
    idle_inputs(); set_alloc('h28, 1, 0, 1, 1, 0, 1); issue_ready = 1; #1;
    check("full_alloc_ready", alloc_ready, 1'b0);
    check("full_free_count", free_count, 4'd0);
    check("full_issue_insn", issue_insn, 'h20); tick();
    #1;
    check("after_issue_free_count", free_count, 4'd1);
    check("after_issue_alloc_ready", alloc_ready, 1'b1); tick();
    idle_inputs(); #1;
    check("refilled_free_count", free_count, 4'd0);

    // Flush with five valid entries and a concurrent alloc.
    idle_inputs(); flush = 1; tick();
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); set_alloc(IW'('h30 + i), 1, 0, 1, 2, 0, 1); tick();
    end
    idle_inputs(); set_alloc('h35, 1, 0, 1, 2, 0, 1); flush = 1; issue_ready = 1; tick();
    idle_inputs(); #1;
    check("flush_free_count", free_count, 4'd8);
    check("flush_issue_valid", issue_valid, 1'b0);

    // Asynchronous reset mid-stream, checked before any clock edge.
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); set_alloc(IW'('h40 + i), 1, 0, 1, 2, 0, 1); tick();
    end
    idle_inputs(); #1;
    check("pre_reset_free_count", free_count, 4'd5);
    reset = 1; #1;
    check("async_rst_free_count", free_count, 4'd8);
    check("async_rst_issue_valid", issue_valid, 1'b0);
    check("async_rst_alloc_ready", alloc_ready, 1'b1);
    mq.delete(); m_locked = 1'b0;
    @(posedge clk); #3 reset = 0;
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      idle_inputs();
      if ($urandom_range(0, 3) != 0)
        set_alloc(IW'('h1000 + c), $urandom, TW'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0),
                  $urandom, TW'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
      cdb_valid   = $urandom_range(0, 1) == 1;
      cdb_tag     = TW'($urandom_range(0, 7));
      cdb_data    = $urandom;
      issue_ready = $urandom_range(0, 3) != 0;
      flush       = $urandom_range(0, 63) == 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
